csr_wport_arb: RTL and testbench

Arbiter and sequencer for the single CSR register-file write port. Two requesters share the port:
- Trap/interrupt controller: CSR write strobes, highest priority, no backpressure.
- Execute stage: CSR instruction writes, valid/ready handshake.

Execute writes are buffered in a small in-order FIFO. The block suppresses buffered writes made stale by a newer trap write, and forwards pending write data to the CSR read path.

---
 rtl/csr_wport_arb.sv | 142 ++++++++++++++
 tb/tb_csr_wport_arb.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_wport_arb.sv
// Single CSR write-port arbiter: trap writes take priority, execute writes are
// buffered in order, stale buffered writes are suppressed, pending data is forwarded.
module csr_wport_arb #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clint_wen_i,
  input  logic [ADDR_W-1:0] clint_waddr_i,
  input  logic [DATA_W-1:0] clint_wdata_i,
  input  logic              exu_wvalid_i,
  output logic              exu_wready_o,
  input  logic [ADDR_W-1:0] exu_waddr_i,
  input  logic [DATA_W-1:0] exu_wdata_i,
  output logic              csr_wen_o,
  output logic [ADDR_W-1:0] csr_waddr_o,
  output logic [DATA_W-1:0] csr_wdata_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              fwd_hit_o,
  output logic [DATA_W-1:0] fwd_data_o,
  output logic              exu_pend_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              kill_n_q [DEPTH];
  logic              kill_n_d [DEPTH];
  logic [ADDR_W-1:0] addr_q   [DEPTH];
  logic [ADDR_W-1:0] addr_d   [DEPTH];
  logic [DATA_W-1:0] data_q   [DEPTH];
  logic [DATA_W-1:0] data_d   [DEPTH];
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic full, empty, push, pop, bypass, store;

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign exu_wready_o = !rst && !full;
  assign exu_pend_o   = !empty;
  assign push         = exu_wvalid_i && exu_wready_o;
  assign pop          = !clint_wen_i && !empty;
  assign bypass       = !clint_wen_i && empty && push;
  assign store        = push && !bypass;

  assign csr_wen_o   = wen_q;
  assign csr_waddr_o = waddr_q;
  assign csr_wdata_o = wdata_q;

  always_comb begin
    kill_n_d = kill_n_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    wen_d    = 1'b0;
    waddr_d  = '0;
    wdata_d  = '0;

    if (clint_wen_i) begin
      wen_d   = 1'b1;
      waddr_d = clint_waddr_i;
      wdata_d = clint_wdata_i;
      for (int i = 0; i < DEPTH; i++) begin
        if (addr_q[i] == clint_waddr_i) kill_n_d[i] = 1'b0;
      end
    end else if (pop) begin
      // a killed head still drains, just without a write strobe
      wen_d    = kill_n_q[rd_ptr_q];
      waddr_d  = addr_q[rd_ptr_q];
      wdata_d  = data_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else if (bypass) begin
      wen_d   = 1'b1;
      waddr_d = exu_waddr_i;
      wdata_d = exu_wdata_i;
    end

    // applied after the kill sweep: a same-cycle push is younger than the trap write
    if (store) begin
      kill_n_d[wr_ptr_q] = 1'b1;
      addr_d[wr_ptr_q]   = exu_waddr_i;
      data_d[wr_ptr_q]   = exu_wdata_i;
      wr_ptr_d           = wr_ptr_q + 1'b1;
    end

    count_d = count_q + CW'(store) - CW'(pop);
  end

  always_comb begin
    logic [PW-1:0] idx;
    idx        = '0;
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    if (wen_q && (waddr_q == rd_addr_i)) begin
      fwd_hit_o  = 1'b1;
      fwd_data_o = wdata_q;
    end
    // head to tail so the youngest live match wins
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && kill_n_q[idx] && (addr_q[idx] == rd_addr_i)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = data_q[idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        kill_n_q[i] <= 1'b0;
        addr_q[i]   <= '0;
        data_q[i]   <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      kill_n_q <= kill_n_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: tb/tb_csr_wport_arb.sv
// Bench for csr_wport_arb: reference model predicts CSR writes into a scoreboard
// queue; a negedge monitor pops and compares every emitted write.
module tb_csr_wport_arb;
  localparam int AW = 12;
  localparam int DW = 64;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          clint_wen_i;
  logic [AW-1:0] clint_waddr_i;
  logic [DW-1:0] clint_wdata_i;
  logic          exu_wvalid_i;
  logic          exu_wready_o;
  logic [AW-1:0] exu_waddr_i;
  logic [DW-1:0] exu_wdata_i;
  logic          csr_wen_o;
  logic [AW-1:0] csr_waddr_o;
  logic [DW-1:0] csr_wdata_o;
  logic [AW-1:0] rd_addr_i;
  logic          fwd_hit_o;
  logic [DW-1:0] fwd_data_o;
  logic          exu_pend_o;

  csr_wport_arb #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .clint_wen_i(clint_wen_i), .clint_waddr_i(clint_waddr_i), .clint_wdata_i(clint_wdata_i),
    .exu_wvalid_i(exu_wvalid_i), .exu_wready_o(exu_wready_o),
    .exu_waddr_i(exu_waddr_i), .exu_wdata_i(exu_wdata_i),
    .csr_wen_o(csr_wen_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .rd_addr_i(rd_addr_i), .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o),
    .exu_pend_o(exu_pend_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  typedef struct packed {
    logic          kill_n;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  int   checks = 0;
  int   errors = 0;
  wr_t  exp_q[$];
  ent_t mq[$];

  always @(negedge clk) begin
    wr_t e;
    if (csr_wen_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got write addr=%h data=%h, expected no write", csr_waddr_o, csr_wdata_o);
      end else begin
        e = exp_q.pop_front();
        if ({csr_waddr_o, csr_wdata_o} !== e) begin
          errors++;
          $display("FAIL sb_write: got addr=%h data=%h, expected addr=%h data=%h",
                   csr_waddr_o, csr_wdata_o, e.a, e.d);
        end
      end
    end
  end

  // One clock: drive inputs, advance the model, sample at the following negedge.
  task automatic cyc(input logic cv, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                     input logic ev, input logic [AW-1:0] ea, input logic [DW-1:0] ed);
    logic rdy, push;
    ent_t h;
    clint_wen_i   = cv;
    clint_waddr_i = ca;
    clint_wdata_i = cd;
    exu_wvalid_i  = ev;
    exu_waddr_i   = ea;
    exu_wdata_i   = ed;
    rdy = (mq.size() != DEPTH);
    #1;
    checks++;
    if (exu_wready_o !== rdy) begin
      errors++;
      $display("FAIL wready: got %b, expected %b", exu_wready_o, rdy);
    end
    push = ev && rdy;
    if (cv) begin
      exp_q.push_back('{ca, cd});
      foreach (mq[i]) if (mq[i].a == ca) mq[i].kill_n = 1'b0;
    end else if (mq.size() != 0) begin
      h = mq.pop_front();
      if (h.kill_n) exp_q.push_back('{h.a, h.d});
    end else if (push) begin
      exp_q.push_back('{ea, ed});
      push = 1'b0;
    end
    if (push) mq.push_back('{1'b1, ea, ed});
    @(posedge clk);
    #1;
    clint_wen_i  = 1'b0;
    exu_wvalid_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({csr_wen_o, csr_waddr_o, csr_wdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_out: got wen=%b addr=%h data=%h, expected all 0", csr_wen_o, csr_waddr_o, csr_wdata_o);
    end
    checks++;
    if (exu_wready_o !== 1'b0 || exu_pend_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got ready=%b pend=%b, expected 0 0", exu_wready_o, exu_pend_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    cyc(1'b0, '0, '0, 1'b1, 12'h300, 64'h8);
    checks++;
    if (csr_wen_o !== 1'b1 || csr_waddr_o !== 12'h300 || csr_wdata_o !== 64'h8) begin
      errors++;
      $display("FAIL single_latency: got wen=%b addr=%h data=%h, expected 1 300 8", csr_wen_o, csr_waddr_o, csr_wdata_o);
    end
    checks++;
    if (exu_wready_o !== 1'b1 || exu_pend_o !== 1'b0) begin
      errors++;
      $display("FAIL single_flags: got ready=%b pend=%b, expected 1 0", exu_wready_o, exu_pend_o);
    end
    idle(1);
  endtask

  task automatic test_clint_priority();
    cyc(1'b1, 12'h341, 64'h41, 1'b1, 12'h305, 64'h5);
    cyc(1'b1, 12'h300, 64'h30, 1'b1, 12'h340, 64'h40);
    checks++;
    if (exu_wready_o !== 1'b0 || exu_pend_o !== 1'b1) begin
      errors++;
      $display("FAIL prio_full: got ready=%b pend=%b, expected 0 1", exu_wready_o, exu_pend_o);
    end
    cyc(1'b1, 12'h342, 64'h42, 1'b0, '0, '0);
    idle(3);
    checks++;
    if (exu_pend_o !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL prio_drain: got pend=%b outstanding=%0d, expected 0 0", exu_pend_o, exp_q.size());
    end
  endtask

  task automatic test_kill();
    cyc(1'b1, 12'h341, 64'h1, 1'b1, 12'h300, 64'h1888);
    cyc(1'b1, 12'h300, 64'h80, 1'b0, '0, '0);
    checks++;
    if (csr_waddr_o !== 12'h300 || csr_wdata_o !== 64'h80) begin
      errors++;
      $display("FAIL kill_trap: got addr=%h data=%h, expected 300 80", csr_waddr_o, csr_wdata_o);
    end
    idle(1);
    checks++;
    if (csr_wen_o !== 1'b0 || exu_pend_o !== 1'b0) begin
      errors++;
      $display("FAIL kill_pop: got wen=%b pend=%b, expected 0 0", csr_wen_o, exu_pend_o);
    end
    idle(1);
  endtask

  task automatic test_same_cycle();
    cyc(1'b1, 12'h300, 64'h80, 1'b1, 12'h300, 64'h8);
    checks++;
    if (csr_wdata_o !== 64'h80 || exu_pend_o !== 1'b1) begin
      errors++;
      $display("FAIL same_first: got data=%h pend=%b, expected 80 1", csr_wdata_o, exu_pend_o);
    end
    idle(1);
    checks++;
    if (csr_wen_o !== 1'b1 || csr_wdata_o !== 64'h8) begin
      errors++;
      $display("FAIL same_second: got wen=%b data=%h, expected 1 8", csr_wen_o, csr_wdata_o);
    end
    idle(1);
  endtask

  task automatic test_forward();
    cyc(1'b1, 12'h341, 64'h11, 1'b1, 12'h305, 64'hA);
    cyc(1'b1, 12'h342, 64'h22, 1'b1, 12'h305, 64'hB);
    rd_addr_i = 12'h305;
    #1;
    checks++;
    if (fwd_hit_o !== 1'b1 || fwd_data_o !== 64'hB) begin
      errors++;
      $display("FAIL fwd_young: got hit=%b data=%h, expected 1 b", fwd_hit_o, fwd_data_o);
    end
    rd_addr_i = 12'h341;
    #1;
    checks++;
    if (fwd_hit_o !== 1'b0 || fwd_data_o !== 64'h0) begin
      errors++;
      $display("FAIL fwd_miss: got hit=%b data=%h, expected 0 0", fwd_hit_o, fwd_data_o);
    end
    rd_addr_i = 12'h342;
    #1;
    checks++;
    if (fwd_hit_o !== 1'b1 || fwd_data_o !== 64'h22) begin
      errors++;
      $display("FAIL fwd_outreg: got hit=%b data=%h, expected 1 22", fwd_hit_o, fwd_data_o);
    end
    idle(1);
    rd_addr_i = 12'h305;
    #1;
    checks++;
    if (fwd_hit_o !== 1'b1 || fwd_data_o !== 64'hB) begin
      errors++;
      $display("FAIL fwd_drain: got hit=%b data=%h, expected 1 b", fwd_hit_o, fwd_data_o);
    end
    idle(2);
    rd_addr_i = '0;
  endtask

  task automatic test_async_reset();
    cyc(1'b1, 12'h341, 64'h3, 1'b1, 12'h310, 64'h1);
    cyc(1'b1, 12'h342, 64'h4, 1'b1, 12'h311, 64'h2);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (csr_wen_o !== 1'b0 || exu_pend_o !== 1'b0 || exu_wready_o !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: got wen=%b pend=%b ready=%b, expected 0 0 0", csr_wen_o, exu_pend_o, exu_wready_o);
    end
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
    idle(4);
    checks++;
    if (exu_wready_o !== 1'b1 || exu_pend_o !== 1'b0) begin
      errors++;
      $display("FAIL post_rst: got ready=%b pend=%b, expected 1 0", exu_wready_o, exu_pend_o);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clint_wen_i = 1'b0; clint_waddr_i = '0; clint_wdata_i = '0;
    exu_wvalid_i = 1'b0; exu_waddr_i = '0; exu_wdata_i = '0;
    rd_addr_i = '0;
    test_reset();
    test_single();
    test_clint_priority();
    test_kill();
    test_same_cycle();
    test_forward();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d writes never emitted, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
